// File: rtl/fifo_prefetch_reader.sv
// fifo_prefetch_reader
// Read-side adapter for a registered-output FIFO (dout valid one cycle after
// rd_en). Reads are issued ahead of demand and landed words are held in a
// small ring buffer. The buffer head is presented as a first-word-fall-through
// valid/ready stream that can move one word per clock.
// fifo_rd_en depends combinationally on out_rdy, because a pop in this cycle
// frees a slot for a read issued in this cycle. out_vld and out_data come only
// from registered state, so there is no path from fifo_dout to the outputs.

module fifo_prefetch_reader #(
   parameter  int WIDTH     = 72,
   parameter  int BUF_DEPTH = 2,
   localparam int BUF_BITS  = $clog2(BUF_DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] fifo_dout,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   output logic [WIDTH-1:0] out_data,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic             pending,
   output logic             overflow_err
);

   localparam logic [BUF_BITS+1:0] L_DEPTH_OCC = (BUF_BITS+2)'(BUF_DEPTH);
   localparam logic [BUF_BITS:0]   L_DEPTH_CNT = (BUF_BITS+1)'(BUF_DEPTH);
   localparam logic [BUF_BITS:0]   L_CNT_ONE   = (BUF_BITS+1)'(1);
   localparam logic [BUF_BITS-1:0] L_PTR_ONE   = BUF_BITS'(1);

   logic [WIDTH-1:0]    r_buf [BUF_DEPTH];
   logic [BUF_BITS:0]   r_count;
   logic [BUF_BITS-1:0] r_wr_ptr;
   logic [BUF_BITS-1:0] r_rd_ptr;
   logic                r_pending;
   logic                r_overflow_err;

   logic                w_pop;
   logic                w_full;
   logic                w_capture;
   logic                w_drop;
   logic [BUF_BITS+1:0] w_occupancy;

   assign out_vld      = (r_count != '0);
   assign out_data     = r_buf[r_rd_ptr];
   assign pending      = r_pending;
   assign overflow_err = r_overflow_err;

   assign w_pop  = out_vld & out_rdy;
   assign w_full = (r_count == L_DEPTH_CNT);

   // Slots committed after this cycle: held words plus the word in flight,
   // minus the word leaving now. One extra bit covers BUF_DEPTH + 1.
   assign w_occupancy = {1'b0, r_count}
                      + {{(BUF_BITS+1){1'b0}}, r_pending}
                      - {{(BUF_BITS+1){1'b0}}, w_pop};

   // Never read an empty FIFO and never read while reset is active.
   assign fifo_rd_en = ~reset & ~fifo_empty & (w_occupancy < L_DEPTH_OCC);

   // A landing word is stored unless the buffer is full with nothing leaving.
   // That case cannot arise from the read throttle above. If it does, the
   // word is dropped.
   assign w_capture = r_pending & (~w_full | w_pop);
   assign w_drop    = r_pending & w_full & ~w_pop;

   // Control state: read-in-flight flag, ring pointers, fill count, sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count        <= '0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_pending      <= 1'b0;
         r_overflow_err <= 1'b0;
      end else begin
         r_pending <= fifo_rd_en;
         if (w_capture) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
         if (w_capture && !w_pop)      r_count <= r_count + L_CNT_ONE;
         else if (!w_capture && w_pop) r_count <= r_count - L_CNT_ONE;
         if (w_drop) r_overflow_err <= 1'b1;
      end
   end

   // Holding storage: write the landed word into the slot at the write pointer.
   // NOTE: the data array is deliberately not reset; out_data is don't-care
   // until out_vld, and leaving it unreset keeps it as plain storage.
   always_ff @(posedge clk) begin
      if (w_capture) r_buf[r_wr_ptr] <= fifo_dout;
   end

`ifndef SYNTHESIS
   // Simulation-only sanity checks on protocol misuse and dropped words.
   always @(posedge clk) begin
      if (!reset) begin
         assert (!w_drop)
            else $error("fifo_prefetch_reader: returned word dropped, no free buffer slot");
         assert (!(fifo_rd_en && fifo_empty))
            else $error("fifo_prefetch_reader: read strobe issued to an empty FIFO");
      end
   end
`endif

endmodule

// File: tb/tb_fifo_prefetch_reader.sv
// tb_fifo_prefetch_reader
// Directed and randomized bench for fifo_prefetch_reader (WIDTH=8, BUF_DEPTH=2).
// A behavioural registered-output FIFO feeds the DUT. A queue of every pushed
// word is the expected output order. Inputs change 2 time units after the
// falling edge, and outputs are sampled in the same quiet window.

module tb_fifo_prefetch_reader;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] fifo_dout;
   logic         fifo_empty;
   logic         fifo_rd_en;
   logic [W-1:0] out_data;
   logic         out_vld;
   logic         out_rdy;
   logic         pending;
   logic         overflow_err;

   logic         wr_en;
   logic [W-1:0] wr_data;

   logic [W-1:0] fq [$];
   logic [W-1:0] exp_q [$];

   int n_pass, n_total, n_fail;
   int rd_pulses, bad_reads, vld_cycles;
   int rd_streak, rd_max, pop_streak, pop_max;

   fifo_prefetch_reader #(.WIDTH(W), .BUF_DEPTH(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .fifo_dout    (fifo_dout),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .out_data     (out_data),
      .out_vld      (out_vld),
      .out_rdy      (out_rdy),
      .pending      (pending),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   // Registered-output FIFO model: dout valid the cycle after rd_en, one write
   // per cycle, and the empty flag is updated on the same edge.
   always @(posedge clk) begin
      if (reset) begin
         fq.delete();
         fifo_empty <= 1'b1;
         fifo_dout  <= '0;
      end else begin
         if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
         if (wr_en) fq.push_back(wr_data);
         fifo_empty <= (fq.size() == 0);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Observe the current cycle: read strobes, bubbles, and delivered words.
   task automatic sample();
      if (!reset) begin
         if (fifo_rd_en) rd_pulses++;
         if (fifo_rd_en && fifo_empty) bad_reads++;
         if (out_vld) vld_cycles++;
         rd_streak = fifo_rd_en ? rd_streak + 1 : 0;
         if (rd_streak > rd_max) rd_max = rd_streak;
         pop_streak = (out_vld && out_rdy) ? pop_streak + 1 : 0;
         if (pop_streak > pop_max) pop_max = pop_streak;
         if (out_vld && out_rdy) begin
            if (exp_q.size() == 0) check("pop_extra", 32'(exp_q.size()), 1);
            else check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
         end
      end
   endtask

   task automatic tick();
      sample();
      @(negedge clk);
      #2;
   endtask

   task automatic push(input logic [W-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      exp_q.push_back(d);
      tick();
      wr_en   = 1'b0;
   endtask

   initial begin
      int rd0, vld0, pushed, cyc;
      n_pass = 0; n_total = 0; n_fail = 0;
      rd_pulses = 0; bad_reads = 0; vld_cycles = 0;
      rd_streak = 0; rd_max = 0; pop_streak = 0; pop_max = 0;
      reset = 1'b1; out_rdy = 1'b0; wr_en = 1'b0; wr_data = '0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state
      check("rst_out_vld", 32'(out_vld), 0);
      check("rst_rd_en", 32'(fifo_rd_en), 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_overflow", 32'(overflow_err), 0);
      tick();

      // Basic: three words, two-cycle latency, back-to-back delivery
      out_rdy = 1'b1;
      rd0 = rd_pulses;
      push(8'h11);
      check("basic_first_rd", 32'(fifo_rd_en), 1);
      check("basic_vld_n", 32'(out_vld), 0);
      push(8'h22);
      check("basic_vld_n1", 32'(out_vld), 0);
      push(8'h33);
      check("basic_vld_n2", 32'(out_vld), 1);
      check("basic_data0", 32'(out_data), 32'h11);
      tick();
      check("basic_data1", 32'(out_data), 32'h22);
      tick();
      check("basic_data2", 32'(out_data), 32'h33);
      tick();
      check("basic_vld_end", 32'(out_vld), 0);
      check("basic_rd_count", 32'(rd_pulses - rd0), 3);

      // Streaming: 16 words with no bubbles in read strobes or deliveries
      rd0 = rd_pulses; rd_max = 0; pop_max = 0;
      for (int i = 0; i < 16; i++) push(8'(i));
      repeat (8) tick();
      check("stream_rd_run", 32'(rd_max), 16);
      check("stream_pop_run", 32'(pop_max), 16);
      check("stream_rd_count", 32'(rd_pulses - rd0), 16);
      check("stream_drained", 32'(exp_q.size()), 0);
      check("stream_overflow", 32'(overflow_err), 0);

      // Backpressure: reads stop at buffer depth, head word holds
      out_rdy = 1'b0;
      rd0 = rd_pulses;
      for (int i = 0; i < 8; i++) push(8'(i));
      repeat (2) tick();
      check("bp_rd_count", 32'(rd_pulses - rd0), 2);
      check("bp_vld", 32'(out_vld), 1);
      check("bp_pending", 32'(pending), 0);
      check("bp_rd_en", 32'(fifo_rd_en), 0);
      for (int i = 0; i < 3; i++) begin
         check("bp_hold", 32'(out_data), 0);
         tick();
      end
      out_rdy = 1'b1; pop_max = 0;
      repeat (14) tick();
      check("bp_release_run", 32'(pop_max), 8);
      check("bp_drained", 32'(exp_q.size()), 0);

      // Single word: one read strobe, one valid cycle
      rd0 = rd_pulses; vld0 = vld_cycles;
      push(8'hA5);
      repeat (6) tick();
      check("single_rd", 32'(rd_pulses - rd0), 1);
      check("single_vld", 32'(vld_cycles - vld0), 1);

      // Reset with a word held and another in flight
      out_rdy = 1'b0;
      push(8'hC1);
      push(8'hC2);
      push(8'hC3);
      check("mid_pre_pending", 32'(pending), 1);
      check("mid_pre_vld", 32'(out_vld), 1);
      reset = 1'b1;
      exp_q.delete();
      tick();
      check("mid_vld", 32'(out_vld), 0);
      check("mid_pending", 32'(pending), 0);
      check("mid_rd_en", 32'(fifo_rd_en), 0);
      reset = 1'b0;
      tick();
      out_rdy = 1'b1;
      push(8'h5A);
      push(8'h6B);
      push(8'h7C);
      repeat (6) tick();
      check("mid_refill_drained", 32'(exp_q.size()), 0);

      // Random writes and random backpressure over 1000 words
      pushed = 0; cyc = 0;
      while (pushed < 1000 && cyc < 20000) begin
         out_rdy = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            exp_q.push_back(wr_data);
            pushed++;
         end else begin
            wr_en = 1'b0;
         end
         tick();
         cyc++;
      end
      wr_en = 1'b0;
      out_rdy = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
      check("rand_pushed", 32'(pushed), 1000);
      check("rand_drained", 32'(exp_q.size()), 0);
      check("no_empty_reads", 32'(bad_reads), 0);
      check("final_overflow", 32'(overflow_err), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
